// File: rtl/gpu_regfile_pkg.sv
// Shared register-bank types and constants for the GPU register file and
// the clients that write into it (writeback arbiter, register_bank_gpu users).
package gpu_regfile_pkg;

    localparam int REG_NUM    = 32;
    localparam int DATA_WIDTH = 64;
    localparam int REG_AW     = $clog2(REG_NUM);

    typedef logic [REG_AW-1:0]     reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    // One writeback request as seen on the shared write port.
    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

endpackage

// File: rtl/gpu_regfile_wb_arbiter_if.sv
// Writeback bus between NUM_REQ execution-unit sources and the arbiter,
// plus the arbitrated write port that feeds the register bank.
// master: the requester side; slave: the arbiter.
interface gpu_regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import gpu_regfile_pkg::*;

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*REG_AW-1:0]     req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    reg_addr_t                     wr_addr;
    reg_data_t                     wr_data;
    logic                          wr_en;
    logic [SRC_W-1:0]              wr_src;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_addr, wr_data, wr_en, wr_src
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_addr, wr_data, wr_en, wr_src
    );

endinterface

// File: rtl/gpu_regfile_wb_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: searches req starting at ptr, wrapping,
// and returns the first set bit as a one-hot grant plus its index.
module rr_priority_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    // Walk the N candidates in priority order beginning at ptr.
    always_comb begin
        int cand;
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/gpu_regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-bank write port among
// NUM_REQ writeback sources. The winner is registered onto wr_addr/wr_data/
// wr_en one cycle after the handshake; writes to r0 are consumed but never
// enabled. Optional macro GPU_WB_ARB_PERF_EN adds a saturating stall_cnt
// output counting cycles in which more than one requester was waiting.
module gpu_regfile_wb_arbiter
    import gpu_regfile_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    gpu_regfile_wb_arbiter_if.slave   wb
`ifdef GPU_WB_ARB_PERF_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   next_ptr;
    logic [SRC_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    wb_req_t            winner;

    rr_priority_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .req (wb.req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Nothing is accepted while reset is held, even if sources are valid.
    assign wb.req_ready = reset_n ? gnt : '0;

    // Pointer advances past the winner; explicit clear keeps it below NUM_REQ
    // when NUM_REQ is not a power of two.
    assign next_ptr = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);

    // Select the granted requester's slice of the flattened request bus.
    always_comb begin
        winner       = '0;
        winner.valid = gnt_any;
        winner.addr  = wb.req_addr[gnt_idx*REG_AW +: REG_AW];
        winner.data  = wb.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Output register and round-robin pointer; async reset discards a pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            rr_ptr     <= '0;
            wb.wr_en   <= 1'b0;
            wb.wr_addr <= '0;
            wb.wr_data <= '0;
            wb.wr_src  <= '0;
        end else if (winner.valid) begin
            rr_ptr     <= next_ptr;
            wb.wr_en   <= (winner.addr != '0);
            wb.wr_addr <= winner.addr;
            wb.wr_data <= winner.data;
            wb.wr_src  <= gnt_idx;
        end else begin
            wb.wr_en   <= 1'b0;
        end
    end

`ifdef GPU_WB_ARB_PERF_EN
    logic stall;

    // A stall cycle is one where at least one valid requester lost arbitration.
    assign stall = ($countones(wb.req_valid) > 1);

    // Saturating stall counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
